// File: rtl/alu_mult_seq_pkg.sv
// Shared ALU opcode constants used by the ALU, the decoder and the
// shift-and-add multiply sequencer.
package alu_mult_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OP_W   = 4;

  localparam logic [OP_W-1:0] ALU_ADD  = 4'd0;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'd1;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'd2;
  localparam logic [OP_W-1:0] ALU_ANDN = 4'd3;
  localparam logic [OP_W-1:0] ALU_ROL  = 4'd4;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'd5;
  localparam logic [OP_W-1:0] ALU_ROR  = 4'd6;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'd7;

endpackage

// File: rtl/alu_mult_seq.sv
// Sequences the shared 16-bit ALU through 16 add/shift-left/shift-right
// iterations to form the low 16 bits of a 16x16 product.
module alu_mult_seq
  import alu_mult_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_SHL  = 3'd2,
    S_SHR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] m_reg, m_next;
  logic [DATA_W-1:0] q_reg, q_next;
  logic [DATA_W-1:0] p_reg, p_next;
  logic [3:0]        cnt_reg, cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      m_reg     <= '0;
      q_reg     <= '0;
      p_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      m_reg     <= m_next;
      q_reg     <= q_next;
      p_reg     <= p_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    m_next     = m_reg;
    q_next     = q_reg;
    p_next     = p_reg;
    cnt_next   = cnt_reg;
    alu_a      = '0;
    alu_b      = '0;
    alu_op     = ALU_ADD;

    unique case (state_reg)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_next     = in_a;
          q_next     = in_b;
          p_next     = '0;
          cnt_next   = '0;
          state_next = S_ADD;
        end else begin
          state_next = S_IDLE;
        end
      end

      // The add is always issued so the run length never depends on data.
      S_ADD: begin
        alu_a  = p_reg;
        alu_b  = m_reg;
        alu_op = ALU_ADD;
        if (q_reg[0]) begin
          p_next = alu_result;
        end
        state_next = S_SHL;
      end

      S_SHL: begin
        alu_a      = m_reg;
        alu_b      = 16'd1;
        alu_op     = ALU_SLL;
        m_next     = alu_result;
        state_next = S_SHR;
      end

      S_SHR: begin
        alu_a  = q_reg;
        alu_b  = 16'd1;
        alu_op = ALU_SRL;
        q_next = alu_result;
        if (cnt_reg == 4'd15) begin
          state_next = S_DONE;
        end else begin
          cnt_next   = cnt_reg + 4'd1;
          state_next = S_ADD;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_reg == S_ADD) || (state_reg == S_SHL) || (state_reg == S_SHR);
  assign done    = (state_reg == S_DONE);
  assign product = p_reg;

endmodule

// File: doc/alu_mult_seq.md
# alu_mult_seq

Multi-cycle controller that sequences the shared 16-bit ALU through a shift-and-add algorithm to produce the low 16 bits of a 16×16 product. It sits between the execute-stage control and the ALU's operand and opcode inputs. It owns the ALU only while `busy` is high; the parent muxes the ALU inputs on `busy`. Only ALU add (0), shift-left (5) and shift-right-logical (7) are used; the ALU flags are ignored.

## Interface
- No parameters; width fixed at 16 bits, opcode at 4 bits.
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `in_a`  in  16  multiplicand; captured on accepted `start`
- `in_b`  in  16  multiplier; captured on accepted `start`
- `alu_a`  out  16  ALU operand A (combinational from state/regs)
- `alu_b`  out  16  ALU operand B
- `alu_op`  out  4  ALU OP_Code
- `alu_result`  in  16  ALU Result, consumed the same cycle
- `busy`  out  1  high while sequencing
- `done`  out  1  one-cycle pulse; `product` valid
- `product`  out  16  low 16 bits of `in_a*in_b`; held until next accepted `start`

## Operation
- Internal registers: M (multiplicand, 16), Q (multiplier, 16), P (accumulator, 16), bit counter cnt (4), state.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE/DONE with `start`=1: M←`in_a`, Q←`in_b`, P←0, cnt←0, go to ADD. Without `start`: DONE→IDLE, IDLE stays.
- ADD: `alu_a`=P, `alu_b`=M, `alu_op`=0. If Q[0]=1, P←`alu_result`; otherwise P holds. The op is always issued, so latency is fixed. Next state SHL.
- SHL: `alu_a`=M, `alu_b`=1, `alu_op`=5; M←`alu_result`. Next state SHR.
- SHR: `alu_a`=Q, `alu_b`=1, `alu_op`=7; Q←`alu_result`. If cnt=15, go to DONE; else cnt←cnt+1 and go to ADD.
- Arithmetic is modulo 2^16; overflow is silently discarded. The result is identical for signed and unsigned operands.
- In IDLE and DONE: `alu_a`=`alu_b`=0, `alu_op`=0.
- `start` is ignored in ADD/SHL/SHR. There is no queuing and no error signal.
- `product` is driven from P. It is only guaranteed meaningful when `done`=1 or after a completed run.

## Timing
- Reset: state=IDLE; M, Q, P, cnt=0; `busy`=0, `done`=0, `product`=0; ALU outputs 0/0/0.
- Reset mid-run aborts immediately to the reset values on the next edge; no `done` pulse.
- `busy`=1 exactly in ADD/SHL/SHR. `done`=1 exactly in DONE.
- Latency: `start` sampled at edge E0. Busy for 48 cycles (16 iterations × 3 ops). The edge after the last SHR (E48) enters DONE, so `done`=1 during the cycle after E48.
- Back-to-back: `start`=1 while `done`=1 is accepted. The next cycle is ADD with `busy`=1, so there is zero idle gap.
- Simultaneous `rst` and `start`: reset wins.
- cnt wrap: cnt reaches 15 only in the final iteration; the 15→0 wrap never occurs inside a run.

## Structure
- Shared package holds the ALU opcode constants: ALU_ADD=4'd0, ALU_SUB=4'd1, ALU_XOR=4'd2, ALU_ANDN=4'd3, ALU_ROL=4'd4, ALU_SLL=4'd5, ALU_ROR=4'd6, ALU_SRL=4'd7. The same constants are used by ALU and decode.
- State encoding is local to this module (3-bit).
- No sub-module. The ALU is instantiated by the parent, never inside this block.

## Test plan
- `in_a`=3, `in_b`=5, `start` pulse → after 48 busy cycles, `done` pulse with `product`=0x000F; `product` still 0x000F 10 cycles later.
- 0xFFFF × 0xFFFF → `product`=0x0001. 0x00FF × 0x0101 → 0xFFFF. 0x0100 × 0x0100 → 0x0000 (overflow discarded).
- 0x1234 × 0 → 0x0000. Also check ALU sees opcode sequence 0,5,7 repeated 16 times, with `alu_b`=1 on every shift.
- `start` with 7×9; assert `start` with 2×2 at busy cycle 10 → ignored, `done` at the original time with 0x003F.
- `rst` at busy cycle 20 → next cycle IDLE, `busy`=0, `product`=0, no `done`. A subsequent 4×4 run yields 0x0010.
- `start` held high through `done` with 6×7 then 2×3 → `done` with 0x002A, then immediately `busy`, then `done` 49 cycles later with 0x0006.
